// File: rtl/z80_bus_ctrl.sv
// Bus/timing glue for the Z80 soft core: fractional clock enable, ROM wait
// states, prioritised IM2 interrupt arbitration and NMI pulse stretching.
module z80_bus_ctrl #(
  parameter int unsigned CEN_NUM  = 1,
  parameter int unsigned CEN_DEN  = 1,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned WAIT_CYC = 1,
  parameter logic [15:0] REG_BASE = 16'h0000,
  parameter logic [15:0] REG_MASK = 16'h8000,
  parameter int unsigned IRQ_N    = 2,
  parameter logic [7:0]  VEC_BASE = 8'hE0,
  parameter int unsigned NMI_LEN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             cen,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_nmreq,
  input  logic             cpu_nrfsh,
  input  logic             cpu_niorq,
  input  logic             cpu_nm1,
  output logic             cpu_nwait,
  output logic             cpu_nint,
  output logic             cpu_nnmi,
  input  logic [IRQ_N-1:0] irq_set,
  input  logic [IRQ_N-1:0] irq_enable,
  input  logic             nmi_set,
  output logic             ack_active,
  output logic [7:0]       ack_vector,
  output logic [IRQ_N-1:0] irq_pending
);

  localparam logic [ACC_W-1:0] NUM_W = ACC_W'(CEN_NUM);
  localparam logic [ACC_W-1:0] DEN_W = ACC_W'(CEN_DEN);
  localparam int WCNT_W = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);
  localparam int NCNT_W = (NMI_LEN < 2) ? 1 : $clog2(NMI_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } wait_state_t;

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic              cen_q, cen_d;

  wait_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              nwait_q, nwait_d;
  logic              hit;

  logic [IRQ_N-1:0]  pending_q, pending_d;
  logic [IRQ_N-1:0]  qual, low_oh, clr;
  logic              nint_q, nint_d;
  logic              ack_seen_q, ack_seen_d;
  logic              ack_active_q, ack_active_d;
  logic [7:0]        vec_q, vec_d;
  logic [2:0]        idx;
  logic              ack_now, ack_start;

  logic [NCNT_W-1:0] ncnt_q, ncnt_d;
  logic              nnmi_q, nnmi_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      cen_q        <= 1'b0;
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      nwait_q      <= 1'b1;
      pending_q    <= '0;
      nint_q       <= 1'b1;
      ack_seen_q   <= 1'b0;
      ack_active_q <= 1'b0;
      vec_q        <= VEC_BASE;
      ncnt_q       <= '0;
      nnmi_q       <= 1'b1;
    end else begin
      acc_q        <= acc_d;
      cen_q        <= cen_d;
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      nwait_q      <= nwait_d;
      pending_q    <= pending_d;
      nint_q       <= nint_d;
      ack_seen_q   <= ack_seen_d;
      ack_active_q <= ack_active_d;
      vec_q        <= vec_d;
      ncnt_q       <= ncnt_d;
      nnmi_q       <= nnmi_d;
    end
  end

  // Fractional accumulator: the remainder is carried, so the long-run rate is exact.
  always_comb begin
    acc_sum = acc_q + NUM_W;
    acc_d   = acc_sum;
    cen_d   = 1'b0;
    if (acc_sum >= DEN_W) begin
      acc_d = acc_sum - DEN_W;
      cen_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    nwait_d = nwait_q;
    hit     = !cpu_nmreq && cpu_nrfsh && ((cpu_addr & REG_MASK) == REG_BASE);
    case (state_q)
      ST_IDLE: begin
        if (cen_q && hit && (WAIT_CYC != 0)) begin
          nwait_d = 1'b0;
          wcnt_d  = WCNT_W'(WAIT_CYC);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cen_q) begin
          if (wcnt_q <= WCNT_W'(1)) begin
            wcnt_d  = '0;
            nwait_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            wcnt_d = wcnt_q - WCNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (cpu_nmreq) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        nwait_d = 1'b1;
      end
    endcase
  end

  // Ack is edge-detected so one long IORQ/M1 cycle only consumes one source.
  always_comb begin
    qual         = pending_q & irq_enable;
    low_oh       = qual & (~qual + IRQ_N'(1));
    ack_now      = !cpu_nm1 && !cpu_niorq;
    ack_start    = ack_now && !ack_seen_q;
    ack_seen_d   = ack_now;
    idx          = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (qual[i]) idx = 3'(i);
    end
    clr          = '0;
    vec_d        = vec_q;
    ack_active_d = ack_active_q;
    if (ack_active_q && cpu_niorq) ack_active_d = 1'b0;
    if (ack_start) begin
      ack_active_d = 1'b1;
      clr          = low_oh;
      vec_d        = (|qual) ? (VEC_BASE + {4'b0000, idx, 1'b0}) : 8'hFF;
    end
    pending_d = (pending_q & ~clr) | irq_set;
    nint_d    = ~|qual;
  end

  // A new request while the pulse is active only reloads, so the CPU sees one edge.
  always_comb begin
    ncnt_d = ncnt_q;
    nnmi_d = nnmi_q;
    if (nmi_set) begin
      ncnt_d = NCNT_W'(NMI_LEN);
      nnmi_d = 1'b0;
    end else if (!nnmi_q && cen_q) begin
      if (ncnt_q <= NCNT_W'(1)) begin
        ncnt_d = '0;
        nnmi_d = 1'b1;
      end else begin
        ncnt_d = ncnt_q - NCNT_W'(1);
      end
    end
  end

  assign cen         = cen_q;
  assign cpu_nwait   = (WAIT_CYC == 0) ? 1'b1 : nwait_q;
  assign cpu_nint    = nint_q;
  assign cpu_nnmi    = nnmi_q;
  assign ack_active  = ack_active_q;
  assign ack_vector  = vec_q;
  assign irq_pending = pending_q;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Scoreboard bench for z80_bus_ctrl: three instances cover the 1/1 bus path,
// the 1/2 NMI stretch and the 3/40 clock-enable rate.
`timescale 1ns/1ps
module tb_z80_bus_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_nmreq, cpu_nrfsh, cpu_niorq, cpu_nm1;
  logic [1:0]  irq_set, irq_enable;
  logic        nmi_set;

  logic       a_cen, a_nwait, a_nint, a_nnmi, a_ack_active;
  logic [7:0] a_ack_vector;
  logic [1:0] a_pending;
  logic       b_cen, b_nwait, b_nint, b_nnmi, b_ack_active;
  logic [7:0] b_ack_vector;
  logic [1:0] b_pending;
  logic       c_cen, c_nwait, c_nint, c_nnmi, c_ack_active;
  logic [7:0] c_ack_vector;
  logic [1:0] c_pending;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  always #5 clk = ~clk;

  z80_bus_ctrl #(.CEN_NUM(1), .CEN_DEN(1), .WAIT_CYC(2), .REG_BASE(16'h8000),
                 .REG_MASK(16'h8000), .IRQ_N(2), .VEC_BASE(8'hE0), .NMI_LEN(4)) u_a (
    .clk(clk), .reset(reset), .cen(a_cen), .cpu_addr(cpu_addr), .cpu_nmreq(cpu_nmreq),
    .cpu_nrfsh(cpu_nrfsh), .cpu_niorq(cpu_niorq), .cpu_nm1(cpu_nm1), .cpu_nwait(a_nwait),
    .cpu_nint(a_nint), .cpu_nnmi(a_nnmi), .irq_set(irq_set), .irq_enable(irq_enable),
    .nmi_set(nmi_set), .ack_active(a_ack_active), .ack_vector(a_ack_vector),
    .irq_pending(a_pending));

  z80_bus_ctrl #(.CEN_NUM(1), .CEN_DEN(2), .WAIT_CYC(1), .IRQ_N(2), .NMI_LEN(4)) u_b (
    .clk(clk), .reset(reset), .cen(b_cen), .cpu_addr(cpu_addr), .cpu_nmreq(cpu_nmreq),
    .cpu_nrfsh(cpu_nrfsh), .cpu_niorq(cpu_niorq), .cpu_nm1(cpu_nm1), .cpu_nwait(b_nwait),
    .cpu_nint(b_nint), .cpu_nnmi(b_nnmi), .irq_set(irq_set), .irq_enable(irq_enable),
    .nmi_set(nmi_set), .ack_active(b_ack_active), .ack_vector(b_ack_vector),
    .irq_pending(b_pending));

  z80_bus_ctrl #(.CEN_NUM(3), .CEN_DEN(40), .WAIT_CYC(1), .IRQ_N(2), .NMI_LEN(4)) u_c (
    .clk(clk), .reset(reset), .cen(c_cen), .cpu_addr(cpu_addr), .cpu_nmreq(cpu_nmreq),
    .cpu_nrfsh(cpu_nrfsh), .cpu_niorq(cpu_niorq), .cpu_nm1(cpu_nm1), .cpu_nwait(c_nwait),
    .cpu_nint(c_nint), .cpu_nnmi(c_nnmi), .irq_set(irq_set), .irq_enable(irq_enable),
    .nmi_set(nmi_set), .ack_active(c_ack_active), .ack_vector(c_ack_vector),
    .irq_pending(c_pending));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total_cnt++;
    if (obs !== req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic popCompare(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkOutput(e.tag, obs, e.val);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic nmreq, input logic nrfsh,
                               input logic niorq, input logic nm1);
    cpu_addr  = addr;
    cpu_nmreq = nmreq;
    cpu_nrfsh = nrfsh;
    cpu_niorq = niorq;
    cpu_nm1   = nm1;
  endtask

  task automatic runAccess(input logic [15:0] addr, input logic nrfsh, input int exp_low,
                           input int exp_first, input string tag);
    int low = 0;
    int first = -1;
    pushExpected({tag, "_low"}, exp_low);
    pushExpected({tag, "_first"}, exp_first);
    applyStimulus(addr, 1'b0, nrfsh, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (!a_nwait) begin
        low++;
        if (first < 0) first = i;
      end
    end
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    popCompare(low);
    popCompare(first);
  endtask

  task automatic alignNmi(input string tag);
    int found = 0;
    pushExpected(tag, 1);
    for (int i = 0; i < 4 && found == 0; i++) begin
      step();
      if (b_cen) found = 1;
    end
    popCompare(found);
  endtask

  task automatic runNmi(input int second_at, input int window, input int exp_low, input string tag);
    int   low = 0;
    int   falls = 0;
    logic prev;
    pushExpected({tag, "_low"}, exp_low);
    pushExpected({tag, "_falls"}, 1);
    prev    = b_nnmi;
    nmi_set = 1'b1;
    for (int i = 1; i <= window; i++) begin
      step();
      nmi_set = (i == second_at);
      if (!b_nnmi) low++;
      if (prev && !b_nnmi) falls++;
      prev = b_nnmi;
    end
    nmi_set = 1'b0;
    popCompare(low);
    popCompare(falls);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cen_cnt, consec, full_cnt;
    logic prev_cen;

    reset = 1'b1;
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    irq_set    = 2'b00;
    irq_enable = 2'b00;
    nmi_set    = 1'b0;
    repeat (3) step();

    pushExpected("rst_cen", 0);       pushExpected("rst_nwait", 1);
    pushExpected("rst_nint", 1);      pushExpected("rst_nnmi", 1);
    pushExpected("rst_ack_active", 0); pushExpected("rst_vector", 8'hE0);
    pushExpected("rst_pending", 0);   pushExpected("rst_c_cen", 0);
    popCompare(a_cen);        popCompare(a_nwait);
    popCompare(a_nint);       popCompare(a_nnmi);
    popCompare(a_ack_active); popCompare(a_ack_vector);
    popCompare(a_pending);    popCompare(c_cen);

    reset    = 1'b0;
    cen_cnt  = 0;
    consec   = 0;
    full_cnt = 0;
    prev_cen = 1'b0;
    pushExpected("cen_count_3_40", 300);
    pushExpected("cen_consecutive", 0);
    pushExpected("cen_full_rate", 4000);
    for (int i = 0; i < 4000; i++) begin
      step();
      if (c_cen) begin
        cen_cnt++;
        if (prev_cen) consec++;
      end
      prev_cen = c_cen;
      if (a_cen) full_cnt++;
    end
    popCompare(cen_cnt);
    popCompare(consec);
    popCompare(full_cnt);

    runAccess(16'h8123, 1'b1, 2, 1, "wait_hit");
    runAccess(16'h4000, 1'b1, 0, -1, "wait_miss");
    runAccess(16'h8000, 1'b0, 0, -1, "wait_rfsh");

    irq_enable = 2'b11;
    irq_set    = 2'b11;
    step();
    irq_set = 2'b00;
    pushExpected("irq_pending_set", 2'b11);
    pushExpected("irq_nint_latency", 1);
    popCompare(a_pending);
    popCompare(a_nint);
    step();
    pushExpected("irq_nint_low", 0);
    popCompare(a_nint);

    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    pushExpected("ack1_active", 1);
    pushExpected("ack1_vector", 8'hE0);
    pushExpected("ack1_pending", 2'b10);
    popCompare(a_ack_active);
    popCompare(a_ack_vector);
    popCompare(a_pending);
    step();
    pushExpected("ack1_nint", 0);
    pushExpected("ack1_held", 1);
    popCompare(a_nint);
    popCompare(a_ack_active);
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    pushExpected("ack1_drop", 0);
    popCompare(a_ack_active);

    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    pushExpected("ack2_vector", 8'hE2);
    pushExpected("ack2_pending", 2'b00);
    pushExpected("ack2_nint_same", 0);
    popCompare(a_ack_vector);
    popCompare(a_pending);
    popCompare(a_nint);
    step();
    pushExpected("ack2_nint_after", 1);
    popCompare(a_nint);
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step();

    irq_set = 2'b01;
    step();
    irq_set = 2'b01;
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    irq_set = 2'b00;
    pushExpected("setwins_vector", 8'hE0);
    pushExpected("setwins_pending", 2'b01);
    popCompare(a_ack_vector);
    popCompare(a_pending);
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step();

    irq_enable = 2'b00;
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    pushExpected("spur_vector", 8'hFF);
    pushExpected("spur_pending", 2'b01);
    pushExpected("spur_active", 1);
    popCompare(a_ack_vector);
    popCompare(a_pending);
    popCompare(a_ack_active);
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    pushExpected("masked_nint", 1);
    pushExpected("vector_hold", 8'hFF);
    popCompare(a_nint);
    popCompare(a_ack_vector);

    irq_enable = 2'b11;
    irq_set    = 2'b11;
    step();
    irq_set = 2'b00;
    step();
    applyStimulus(16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    pushExpected("pre_rst_nwait", 0);
    pushExpected("pre_rst_active", 1);
    popCompare(a_nwait);
    popCompare(a_ack_active);
    reset = 1'b1;
    step();
    pushExpected("midrst_nwait", 1);
    pushExpected("midrst_active", 0);
    pushExpected("midrst_pending", 0);
    pushExpected("midrst_cen", 0);
    pushExpected("midrst_vector", 8'hE0);
    popCompare(a_nwait);
    popCompare(a_ack_active);
    popCompare(a_pending);
    popCompare(a_cen);
    popCompare(a_ack_vector);
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    step();
    pushExpected("postrst_cen", 1);
    popCompare(a_cen);

    alignNmi("nmi_align1");
    runNmi(0, 16, 8, "nmi_single");
    repeat (3) step();
    alignNmi("nmi_align2");
    runNmi(5, 20, 12, "nmi_extend");

    checkOutput("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
- Parametrised bus/timing controller that sits beside the Z80 soft core in every sound and sub-CPU subsystem.
- Generates the fractional CPU clock enable from the system clock.
- Inserts programmable ROM wait states.
- Arbitrates N prioritised maskable interrupt sources with IM2 vector supply.
- Stretches NMI requests; replaces per-board ad-hoc glue around the CPU.

Parameters:
CEN_NUM, 1, clock-enable numerator (1 <= CEN_NUM <= CEN_DEN)
CEN_DEN, 1, clock-enable denominator; cen rate = clk*CEN_NUM/CEN_DEN
ACC_W, 16, accumulator width; must hold CEN_DEN+CEN_NUM
WAIT_CYC, 1, wait states per region access in cen ticks (0 = disabled)
REG_BASE, 16'h0000, wait-region base address
REG_MASK, 16'h8000, wait-region address mask
IRQ_N, 2, number of interrupt sources (1..8)
VEC_BASE, 8'hE0, IM2 vector for source 0; source i = VEC_BASE+2*i (mod 256)
NMI_LEN, 4, NMI low pulse length in cen ticks (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active high
cen  out  1  CPU clock enable, single-clk pulse
cpu_addr  in  16  CPU address bus
cpu_nmreq  in  1  CPU MREQ, active low
cpu_nrfsh  in  1  CPU RFSH, active low
cpu_niorq  in  1  CPU IORQ, active low
cpu_nm1  in  1  CPU M1, active low
cpu_nwait  out  1  to CPU WAIT, active low
cpu_nint  out  1  to CPU INT, active low
cpu_nnmi  out  1  to CPU NMI, active low
irq_set  in  IRQ_N  per-source set strobes, one-clk pulses
irq_enable  in  IRQ_N  per-source mask, 1 = enabled
nmi_set  in  1  NMI request strobe
ack_active  out  1  high while an interrupt-acknowledge cycle is in progress
ack_vector  out  8  vector to drive on CPU data-in during ack
irq_pending  out  IRQ_N  pending flags, unmasked view

Behaviour:
Reset:
- acc=0; cen=0; cpu_nwait=1; cpu_nint=1; cpu_nnmi=1; ack_active=0; ack_vector=VEC_BASE; irq_pending=0; wait FSM=IDLE; NMI counter=0.
- Reset mid-wait or mid-ack aborts immediately.

Clock enable:
- Every clk: if acc+CEN_NUM >= CEN_DEN then acc <= acc+CEN_NUM-CEN_DEN and cen <= 1; else acc <= acc+CEN_NUM and cen <= 0.
- NUM==DEN gives cen constantly 1 after the first clk out of reset.
- Long-run count is exact: no drift.

Wait FSM (states IDLE, WAIT, HOLD):
- Hit = cpu_nmreq==0 && cpu_nrfsh==1 && (cpu_addr & REG_MASK)==REG_BASE.
- IDLE: when cen && hit && WAIT_CYC>0 -> cpu_nwait=0 on the next clk, cnt=WAIT_CYC, go WAIT.
- WAIT: each cen decrements cnt. When cnt reaches 0, cpu_nwait=1 and go HOLD.
- HOLD: stay until cpu_nmreq==1 sampled on any clk, then IDLE. This gives one insertion per access.
- Refresh cycles never insert waits.
- WAIT_CYC=0: cpu_nwait is tied 1.

Interrupts:
- pending[i] is set on irq_set[i].
- pending[i] is cleared when an ack selects source i.
- Set and clear of the same bit in the same clk: set wins.
- cpu_nint is registered: ~|(pending & irq_enable), one clk latency.
- Masking a bit does not clear its pending flag.
- Ack start is the clk where (cpu_nm1==0 && cpu_niorq==0) first becomes true, detected by edge.
- On ack start:
  - idx = lowest-numbered bit of pending & irq_enable.
  - ack_vector <= VEC_BASE+2*idx.
  - pending[idx] <= 0.
  - ack_active <= 1.
- If no source qualifies at ack start (spurious), ack_vector = 8'hFF and no flag is cleared.
- ack_active drops the clk after cpu_niorq returns high.
- ack_vector holds its value until the next ack.

NMI:
- nmi_set -> cpu_nnmi=0 on the next clk; counter=NMI_LEN.
- Counter decrements per cen; cpu_nnmi returns 1 when the counter hits 0.
- nmi_set while active reloads the counter (pulse extended, no second edge).

Test Plan:
- CEN_NUM=3, CEN_DEN=40, 4000 clk after reset -> exactly 300 cen pulses; never two consecutive cen.
- WAIT_CYC=2, CEN 1/1, read at 0x8123 (REG_BASE=0x8000) -> cpu_nwait low for exactly 2 clk starting one clk after MREQ sampled. Read at 0x4000 -> no wait. Refresh at 0x8000 -> no wait.
- IRQ_N=2, pulse irq_set=2'b11, run ack cycle -> ack_vector=0xE0, pending=2'b10, cpu_nint stays 0. Second ack -> 0xE2, pending=0, cpu_nint=1 one clk later.
- irq_set[0] pulsed in the same clk as the ack that selects source 0 -> pending[0] remains 1. Ack with irq_enable=0 -> ack_vector=0xFF, pending unchanged.
- NMI_LEN=4, CEN 1/2: nmi_set -> cpu_nnmi low 8 clk. Second nmi_set at clk 5 -> low until clk 13, single falling edge.
- Assert reset mid-WAIT and mid-ack -> next clk: cpu_nwait=1, ack_active=0, pending=0, acc=0.
